// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD-to-binary converter.
// The digit range check is used when BCD_TO_BIN_ERR_CHECK_EN is defined.
package bcd_pkg;

    localparam int N_DIGITS  = 3;
    localparam int BIN_W     = 10;
    localparam int BCD_W     = 4 * N_DIGITS;
    localparam int SHIFT_CNT = BIN_W;
    localparam int CNT_W     = $clog2(SHIFT_CNT);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic digit_bad(input logic [3:0] digit);
        return digit > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// One reverse double-dabble correction stage: a digit that reads 8 or more
// after the right shift came from a borrowed 10, so take back 3.
module bcd_digit_corr (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd8) ? (d - 4'd3) : d;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter, one reverse double-dabble shift per clock.
// Define BCD_TO_BIN_ERR_CHECK_EN to reject digits above 9 at acceptance.
//
// state    | meaning
// ST_IDLE  | waiting for i_start; i_bcd captured on acceptance
// ST_SHIFT | shifting digits into the binary register, BIN_W cycles
module bcd_to_bin #(
    parameter int N_DIGITS = 3,
    parameter int BIN_W    = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [4*N_DIGITS-1:0]   i_bcd,
    output logic                    o_busy,
    output logic                    o_valid,
    output logic [BIN_W-1:0]        o_bin,
    output logic                    o_err
);

    import bcd_pkg::*;

    localparam int DIG_W  = 4 * N_DIGITS;
    localparam int CTR_W  = $clog2(BIN_W);
    localparam logic [CTR_W-1:0] LAST_CNT = CTR_W'(BIN_W - 1);

    state_t              state_q;
    logic [DIG_W-1:0]    digit_q;
    logic [BIN_W-1:0]    bin_q;
    logic [CTR_W-1:0]    cnt_q;

    logic [DIG_W-1:0]    digit_sh;
    logic [BIN_W-1:0]    bin_sh;
    logic [DIG_W-1:0]    digit_nx;

    assign {digit_sh, bin_sh} = {1'b0, digit_q, bin_q[BIN_W-1:1]};

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_corr
        bcd_digit_corr u_corr (
            .d (digit_sh[4*g +: 4]),
            .q (digit_nx[4*g +: 4])
        );
    end

`ifdef BCD_TO_BIN_ERR_CHECK_EN
    logic any_bad;
    logic err_q;

    always_comb begin
        any_bad = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            any_bad = any_bad | digit_bad(i_bcd[4*k +: 4]);
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            digit_q <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_bin   <= '0;
            o_err   <= 1'b0;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            o_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        digit_q <= i_bcd;
                        bin_q   <= '0;
                        cnt_q   <= '0;
                        o_busy  <= 1'b1;
                        state_q <= ST_SHIFT;
`ifdef BCD_TO_BIN_ERR_CHECK_EN
                        err_q   <= any_bad;
`endif
                    end
                end
                ST_SHIFT: begin
`ifdef BCD_TO_BIN_ERR_CHECK_EN
                    // A rejected input skips the shift sequence entirely.
                    if (err_q) begin
                        err_q   <= 1'b0;
                        o_bin   <= '0;
                        o_err   <= 1'b1;
                        o_valid <= 1'b1;
                        o_busy  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else
`endif
                    begin
                        digit_q <= digit_nx;
                        bin_q   <= bin_sh;
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            cnt_q   <= '0;
                            o_bin   <= bin_sh;
                            o_err   <= 1'b0;
                            o_valid <= 1'b1;
                            o_busy  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed cases, full 000-999 sweep and
// random digits compared against 100*H + 10*T + O.
module tb_bcd_to_bin;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [11:0] i_bcd;
    logic        o_busy;
    logic        o_valid;
    logic [9:0]  o_bin;
    logic        o_err;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    bcd_to_bin dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_bcd   (i_bcd),
        .o_busy  (o_busy),
        .o_valid (o_valid),
        .o_bin   (o_bin),
        .o_err   (o_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_val(input logic [11:0] b);
        int h, t, o;
        h = int'(b[11:8]);
        t = int'(b[7:4]);
        o = int'(b[3:0]);
        return 100 * h + 10 * t + o;
    endfunction

    task automatic start(input logic [11:0] b);
        i_bcd   = b;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Counts edges since acceptance; i_bcd is scrambled to prove it is not re-sampled.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (o_valid !== 1'b1 && lat < 40) begin
            i_bcd = 12'($urandom);
            @(negedge i_clk);
            lat++;
        end
    endtask

    task automatic conv(input logic [11:0] b, input int exp_bin, input bit chk_bin,
                        input int exp_err, input int exp_lat, input string tag);
        int lat;
        start(b);
        check({tag, "_busy"}, o_busy, 1);
        wait_valid(lat);
        check({tag, "_lat"}, lat, exp_lat);
        if (chk_bin) check({tag, "_bin"}, o_bin, exp_bin);
        check({tag, "_err"}, o_err, exp_err);
        check({tag, "_busy_done"}, o_busy, 0);
        @(negedge i_clk);
        check({tag, "_pulse"}, o_valid, 0);
        if (chk_bin) check({tag, "_hold"}, o_bin, exp_bin);
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge i_clk);
            if (o_valid === 1'b1) pulses++;
        end
    endtask

    initial begin
        int lat, pulses, v;
        logic [11:0] b;

        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_bcd   = '0;
        repeat (2) @(negedge i_clk);
        check("rst_busy", o_busy, 0);
        check("rst_valid", o_valid, 0);
        check("rst_bin", o_bin, 0);
        check("rst_err", o_err, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        conv(12'h255, 255, 1, 0, 10, "c255");

        // back-to-back: second start issued in the o_valid cycle
        start(12'h999);
        wait_valid(lat);
        check("b2b_lat1", lat, 10);
        check("b2b_bin1", o_bin, 999);
        start(12'h000);
        check("b2b_pulse", o_valid, 0);
        check("b2b_busy2", o_busy, 1);
        wait_valid(lat);
        check("b2b_lat2", lat, 10);
        check("b2b_bin2", o_bin, 0);
        @(negedge i_clk);

        // start while busy is ignored
        start(12'h123);
        repeat (4) @(negedge i_clk);
        start(12'h456);
        wait_valid(lat);
        check("ign_lat", lat + 5, 10);
        check("ign_bin", o_bin, 123);
        count_pulses(15, pulses);
        check("ign_pulses", pulses, 0);
        check("ign_hold", o_bin, 123);

        // reset mid-conversion
        start(12'h777);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check("midrst_busy", o_busy, 0);
        check("midrst_valid", o_valid, 0);
        check("midrst_bin", o_bin, 0);
        check("midrst_err", o_err, 0);
        i_rst_n = 1'b1;
        count_pulses(15, pulses);
        check("midrst_pulses", pulses, 0);
        conv(12'h042, 42, 1, 0, 10, "c042");

`ifdef BCD_TO_BIN_ERR_CHECK_EN
        conv(12'h1A3, 0, 1, 1, 1, "err");
        conv(12'h100, 100, 1, 0, 10, "after_err");
`else
        conv(12'h1A3, 0, 0, 0, 10, "nochk");
        conv(12'h100, 100, 1, 0, 10, "after_nochk");
`endif

        for (int n = 0; n < 1000; n++) begin
            b = 12'(((n / 100) << 8) | (((n / 10) % 10) << 4) | (n % 10));
            conv(b, n, 1, 0, 10, "sweep");
        end

        for (int n = 0; n < 200; n++) begin
            b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            v = ref_val(b);
            conv(b, v, 1, 0, 10, "rand");
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
